seg_scan_ctrl: RTL and testbench

Sequencing controller for the two-digit score display. It takes the 7-bit binary display score from the score tracker and converts it to BCD with a multi-cycle repeated-subtract sequencer. It then time-multiplexes one shared 4-bit digit bus between the ones and tens seven-segment decoders at a programmable scan rate. It also applies leading-zero blanking and a game-over blink, and sits between the score tracker and the two segment decoders.

---
 rtl/seg_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Two-digit score display sequencer. Converts the 7-bit binary score to
//   BCD with a repeated-subtract sequencer, then time-multiplexes one shared
//   4-bit digit bus between the ones and tens segment decoders at a
//   programmable scan rate. Adds leading-zero blanking on the tens digit and
//   a blink while the game-over mode is active.
//
// Parameters
//   DIV_W        width of the scan prescaler reload value
//   BLINK_TICKS  scan ticks per blink half-period (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   score_bin    binary score, values above 99 are shown as 99
//   game_over    level, enables the blink
//   refresh_div  scan tick period minus one, in clk cycles (sampled live)
//   digit_out    BCD digit on the shared decoder bus (registered)
//   en_ones      ones decoder enable (registered)
//   en_tens      tens decoder enable (registered)
//   conv_busy    high while a BCD conversion is in progress (registered)
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIV_W       = 10,
    parameter int BLINK_TICKS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       score_bin,
    input  logic             game_over,
    input  logic [DIV_W-1:0] refresh_div,
    output logic [3:0]       digit_out,
    output logic             en_ones,
    output logic             en_tens,
    output logic             conv_busy
);

    localparam int               BLK_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
    localparam logic [6:0]       MAX_SCORE = 7'd99;

    typedef enum logic {
        ST_SCAN = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       last_score_q, last_score_d;
    logic [6:0]       rem_q, rem_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             digit_sel_q, digit_sel_d;
    logic [BLK_W-1:0] blink_q, blink_d;
    logic             blank_phase_q, blank_phase_d;
    logic [3:0]       digit_out_q, digit_out_d;
    logic             en_ones_q, en_ones_d;
    logic             en_tens_q, en_tens_d;
    logic             conv_busy_q, conv_busy_d;
    logic             tick_s;

    // Conversion sequencer: capture a changed score, then subtract tens
    // until the remainder is a single digit; both digits commit together.
    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        ones_d       = ones_q;
        tens_d       = tens_q;
        case (state_q)
            ST_SCAN: begin
                if (score_bin != last_score_q) begin
                    state_d      = ST_CONV;
                    last_score_d = score_bin;
                    rem_d        = (score_bin > MAX_SCORE) ? MAX_SCORE : score_bin;
                    cnt_d        = 4'd0;
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_CONV: begin
                if (rem_q >= 7'd10) begin
                    rem_d = rem_q - 7'd10;
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    ones_d  = rem_q[3:0];
                    tens_d  = cnt_q;
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Scan prescaler, digit slot select and game-over blink phase.
    always_comb begin
        tick_s = (presc_q == refresh_div);
        if (tick_s) begin
            presc_d     = '0;
            digit_sel_d = ~digit_sel_q;
        end else begin
            // Free-running increment: a lowered refresh_div wraps at all-ones.
            presc_d     = presc_q + DIV_W'(1);
            digit_sel_d = digit_sel_q;
        end
        if (!game_over) begin
            blink_d       = '0;
            blank_phase_d = 1'b0;
        end else if (tick_s && (blink_q == BLK_LAST)) begin
            blink_d       = '0;
            blank_phase_d = ~blank_phase_q;
        end else if (tick_s) begin
            blink_d       = blink_q + BLK_W'(1);
            blank_phase_d = blank_phase_q;
        end else begin
            blink_d       = blink_q;
            blank_phase_d = blank_phase_q;
        end
    end

    // Output staging from the current committed digits and scan state.
    always_comb begin
        digit_out_d = digit_sel_q ? tens_q : ones_q;
        en_ones_d   = !digit_sel_q && !blank_phase_q;
        en_tens_d   = digit_sel_q && !blank_phase_q && (tens_q != 4'd0);
        // Tracks the state register so busy is high exactly during CONV.
        conv_busy_d = (state_d == ST_CONV);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_SCAN;
            last_score_q  <= 7'd0;
            rem_q         <= 7'd0;
            cnt_q         <= 4'd0;
            ones_q        <= 4'd0;
            tens_q        <= 4'd0;
            presc_q       <= '0;
            digit_sel_q   <= 1'b0;
            blink_q       <= '0;
            blank_phase_q <= 1'b0;
            digit_out_q   <= 4'd0;
            en_ones_q     <= 1'b0;
            en_tens_q     <= 1'b0;
            conv_busy_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_score_q  <= last_score_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            presc_q       <= presc_d;
            digit_sel_q   <= digit_sel_d;
            blink_q       <= blink_d;
            blank_phase_q <= blank_phase_d;
            digit_out_q   <= digit_out_d;
            en_ones_q     <= en_ones_d;
            en_tens_q     <= en_tens_d;
            conv_busy_q   <= conv_busy_d;
        end
    end

    assign digit_out = digit_out_q;
    assign en_ones   = en_ones_q;
    assign en_tens   = en_tens_q;
    assign conv_busy = conv_busy_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl. Inputs change on the falling edge,
//   outputs are sampled on the falling edge after each rising edge.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIV_W = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       score_bin;
    logic             game_over;
    logic [DIV_W-1:0] refresh_div;
    logic [3:0]       digit_out;
    logic             en_ones;
    logic             en_tens;
    logic             conv_busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] hist [0:31];

    seg_scan_ctrl #(.DIV_W(DIV_W), .BLINK_TICKS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .score_bin  (score_bin),
        .game_over  (game_over),
        .refresh_div(refresh_div),
        .digit_out  (digit_out),
        .en_ones    (en_ones),
        .en_tens    (en_tens),
        .conv_busy  (conv_busy)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Display check with no blanking: the active slot follows en_ones.
    task automatic disp_chk(input logic [3:0] o, input logic [3:0] t);
        logic sel;
        sel = ~en_ones;
        check_val("digit_out", {4'd0, digit_out}, {4'd0, (sel ? t : o)});
        check_val("en_tens", {7'd0, en_tens}, {7'd0, (sel && (t != 4'd0))});
    endtask

    // Apply a score and follow the conversion for n cycles after capture.
    task automatic run_conv(input logic [6:0] s, input logic [3:0] oo, input logic [3:0] ot,
                            input logic [3:0] no, input logic [3:0] nt,
                            input int lat, input int n);
        score_bin = s;
        for (int j = 0; j < n; j++) begin
            cycle();
            check_val("conv_busy", {7'd0, conv_busy}, (j < lat) ? 8'd1 : 8'd0);
            if (j <= lat) disp_chk(oo, ot);
            else          disp_chk(no, nt);
            hist[j] = digit_out;
        end
    endtask

    initial begin
        rst         = 1'b1;
        score_bin   = 7'd0;
        game_over   = 1'b0;
        refresh_div = 10'd3;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_digit", {4'd0, digit_out}, 8'd0);
        check_val("rst_en_ones", {7'd0, en_ones}, 8'd0);
        check_val("rst_en_tens", {7'd0, en_tens}, 8'd0);
        check_val("rst_busy", {7'd0, conv_busy}, 8'd0);
        rst = 1'b0;

        // Score 0 after reset: no conversion, ones slot 4 on / 4 off.
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check_val("idle_en_ones", {7'd0, en_ones}, ((((k - 1) / 4) % 2) == 0) ? 8'd1 : 8'd0);
            check_val("idle_en_tens", {7'd0, en_tens}, 8'd0);
            check_val("idle_digit", {4'd0, digit_out}, 8'd0);
            check_val("idle_busy", {7'd0, conv_busy}, 8'd0);
        end

        // 0 -> 37: four CONV cycles, then 7/3 alternating every 2 cycles.
        refresh_div = 10'd1;
        run_conv(7'd37, 4'd0, 4'd0, 4'd7, 4'd3, 4, 13);
        for (int i = 5; i <= 10; i++) begin
            check_val("alt_37", {7'd0, (hist[i + 2] != hist[i])}, 8'd1);
        end

        // 120 clamps to 99: ten CONV cycles, then 9/9.
        run_conv(7'd120, 4'd7, 4'd3, 4'd9, 4'd9, 10, 15);

        // 12, changed to 45 one cycle into conversion: 1/2 then 4/5.
        score_bin = 7'd12;
        for (int j = 0; j < 13; j++) begin
            cycle();
            if (j == 0) score_bin = 7'd45;
            check_val("busy_12_45", {7'd0, conv_busy},
                      ((j < 2) || ((j >= 3) && (j < 8))) ? 8'd1 : 8'd0);
            if (j <= 2)      disp_chk(4'd9, 4'd9);
            else if (j <= 8) disp_chk(4'd2, 4'd1);
            else             disp_chk(4'd5, 4'd4);
        end

        // Reset during CONV of 88, then conversion restarts and commits 8/8.
        score_bin = 7'd88;
        cycle();
        check_val("busy_88_a", {7'd0, conv_busy}, 8'd1);
        cycle();
        check_val("busy_88_b", {7'd0, conv_busy}, 8'd1);
        rst         = 1'b1;
        refresh_div = 10'd0;
        #1;
        check_val("midrst_digit", {4'd0, digit_out}, 8'd0);
        check_val("midrst_en_ones", {7'd0, en_ones}, 8'd0);
        check_val("midrst_en_tens", {7'd0, en_tens}, 8'd0);
        check_val("midrst_busy", {7'd0, conv_busy}, 8'd0);
        cycle();
        rst = 1'b0;
        run_conv(7'd88, 4'd0, 4'd0, 4'd8, 4'd8, 9, 13);

        // Game-over blink, tick every cycle, 2 ticks per half-period.
        game_over = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            check_val("blink_vis", {7'd0, (en_ones | en_tens)},
                      ((((k - 1) / 2) % 2) == 0) ? 8'd1 : 8'd0);
            check_val("blink_excl", {7'd0, (en_ones & en_tens)}, 8'd0);
        end
        // Dropped during a blank phase: visible again on the second sample.
        game_over = 1'b0;
        cycle();
        check_val("go_fall_1", {7'd0, (en_ones | en_tens)}, 8'd0);
        cycle();
        check_val("go_fall_2", {7'd0, (en_ones | en_tens)}, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
